// File: rtl/ahb_lite_manager_if.sv
// Bundle of the command/response streams and the AHB-Lite manager signals.
// The master modport is the manager's view of the bundle; the slave modport is the view of the blocks around it.
interface ahb_lite_manager_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
) ();
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [AddressWidth-1:0] cmd_addr;
  logic [2:0]              cmd_size;
  logic [DataWidth-1:0]    cmd_wdata;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DataWidth-1:0]    rsp_rdata;
  logic                    rsp_error;

  logic [AddressWidth-1:0] haddr;
  logic [1:0]              htrans;
  logic                    hwrite;
  logic [2:0]              hsize;
  logic [2:0]              hburst;
  logic [DataWidth-1:0]    hwdata;
  logic [DataWidth-1:0]    hrdata;
  logic                    hready;
  logic                    hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
    input  hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output haddr, htrans, hwrite, hsize, hburst, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
    output hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  haddr, htrans, hwrite, hsize, hburst, hwdata
  );
endinterface

// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: turns a valid/ready command stream into pipelined SINGLE/NONSEQ transfers
// and returns the completions, in command order, through a first-word fall-through response FIFO.
module ahb_lite_manager #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int RspDepth     = 4
) (
  input logic                clk,
  input logic                rst,
  ahb_lite_manager_if.master bus
);
  localparam int CntW = $clog2(RspDepth + 1);
  localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(RspDepth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(RspDepth - 1);
  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  typedef enum logic [1:0] {A_IDLE, A_ACTIVE, A_CANCEL, A_REPLAY} a_state_t;
  a_state_t a_state_reg, a_state_next;

  logic [AddressWidth-1:0] haddr_reg;
  logic                    hwrite_reg;
  logic [2:0]              hsize_reg;
  logic [DataWidth-1:0]    wdata_hold_reg;
  logic                    dp_valid_reg;
  logic                    dp_write_reg;
  logic [DataWidth-1:0]    hwdata_reg;
  logic [CntW-1:0]         inflight_reg;

  // Each entry is {error, rdata}.
  logic [DataWidth:0]      fifo_mem [RspDepth];
  logic [PtrW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CntW-1:0]         fifo_cnt_reg;
  logic [DataWidth:0]      head;

  logic addr_busy, addr_advance, cmd_ready, cmd_accept, dp_done, rsp_valid, rsp_pop;

  always_comb begin
    addr_busy    = (a_state_reg == A_ACTIVE) || (a_state_reg == A_REPLAY);
    addr_advance = addr_busy && bus.hready && !bus.hresp;
    cmd_ready    = !rst && (inflight_reg < DepthC) && ((a_state_reg == A_IDLE) || addr_advance);
    cmd_accept   = bus.cmd_valid && cmd_ready;
    dp_done      = dp_valid_reg && bus.hready;
    rsp_valid    = (fifo_cnt_reg != '0);
    rsp_pop      = rsp_valid && bus.rsp_ready;
    head         = fifo_mem[rd_ptr_reg];
  end

  always_comb begin
    a_state_next = a_state_reg;
    case (a_state_reg)
      A_IDLE:   if (cmd_accept) a_state_next = A_ACTIVE;
      A_ACTIVE, A_REPLAY: begin
        if (bus.hready && !bus.hresp)
          a_state_next = cmd_accept ? A_ACTIVE : A_IDLE;
        else if (!bus.hready && bus.hresp)
          a_state_next = A_CANCEL;  // withdraw so the retained transfer is replayed after the ERROR
      end
      A_CANCEL: if (bus.hready) a_state_next = A_REPLAY;
      default:  a_state_next = A_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_state_reg    <= A_IDLE;
      haddr_reg      <= '0;
      hwrite_reg     <= 1'b0;
      hsize_reg      <= '0;
      wdata_hold_reg <= '0;
      dp_valid_reg   <= 1'b0;
      dp_write_reg   <= 1'b0;
      hwdata_reg     <= '0;
      inflight_reg   <= '0;
    end else begin
      a_state_reg <= a_state_next;
      if (cmd_accept) begin
        haddr_reg      <= bus.cmd_addr;
        hwrite_reg     <= bus.cmd_write;
        hsize_reg      <= bus.cmd_size;
        wdata_hold_reg <= bus.cmd_wdata;
      end
      if (addr_advance) begin
        dp_valid_reg <= 1'b1;
        dp_write_reg <= hwrite_reg;
        hwdata_reg   <= wdata_hold_reg;
      end else if (bus.hready) begin
        dp_valid_reg <= 1'b0;
      end
      case ({cmd_accept, rsp_pop})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (dp_done) wr_ptr_reg <= (wr_ptr_reg == LastPtr) ? '0 : wr_ptr_reg + 1'b1;
      if (rsp_pop) rd_ptr_reg <= (rd_ptr_reg == LastPtr) ? '0 : rd_ptr_reg + 1'b1;
      case ({dp_done, rsp_pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (dp_done) fifo_mem[wr_ptr_reg] <= {bus.hresp, dp_write_reg ? {DataWidth{1'b0}} : bus.hrdata};
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_valid ? head[DataWidth-1:0] : '0;
  assign bus.rsp_error = rsp_valid && head[DataWidth];
  assign bus.haddr     = haddr_reg;
  assign bus.htrans    = addr_busy ? HtransNonseq : HtransIdle;
  assign bus.hwrite    = hwrite_reg;
  assign bus.hsize     = hsize_reg;
  assign bus.hburst    = 3'b000;
  assign bus.hwdata    = hwdata_reg;
endmodule

// File: tb/tb_ahb_lite_manager.sv
// Directed bench for ahb_lite_manager with a small AHB-Lite memory subordinate
// that can add wait states or a two-cycle ERROR on one selected address.
module tb_ahb_lite_manager;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_lite_manager_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();
  ahb_lite_manager #(.AddressWidth(AW), .DataWidth(DW), .RspDepth(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int rsp_seen = 0;
  int acc_cyc[$];
  int ns_cyc[$];
  int rsp_cyc[$];
  logic [32:0] exp_q[$];
  logic [31:0] wait_addr = 32'hFFFF_FFFF;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Memory subordinate: 3 wait states on wait_addr, two-cycle ERROR on err_addr.
  logic [31:0] mem [4096];
  logic s_dp_reg, s_write_reg, s_err_reg, s_err2_reg;
  logic [31:0] s_addr_reg;
  int s_wait_reg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_dp_reg <= 1'b0;
      s_write_reg <= 1'b0;
      s_err_reg <= 1'b0;
      s_err2_reg <= 1'b0;
      s_addr_reg <= '0;
      s_wait_reg <= 0;
    end else if (bus.hready) begin
      if (bus.htrans == 2'b10) begin
        s_dp_reg <= 1'b1;
        s_addr_reg <= bus.haddr;
        s_write_reg <= bus.hwrite;
        s_wait_reg <= (bus.haddr == wait_addr) ? 3 : 0;
        s_err_reg <= (bus.haddr == err_addr);
        s_err2_reg <= 1'b0;
      end else begin
        s_dp_reg <= 1'b0;
      end
    end else if (s_wait_reg != 0) begin
      s_wait_reg <= s_wait_reg - 1;
    end else if (s_err_reg) begin
      s_err2_reg <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (bus.hready && s_dp_reg && s_write_reg && !s_err_reg) mem[s_addr_reg[13:2]] <= bus.hwdata;
  end

  assign bus.hready = !s_dp_reg || (s_wait_reg == 0 && (!s_err_reg || s_err2_reg));
  assign bus.hresp  = s_dp_reg && s_wait_reg == 0 && s_err_reg;
  assign bus.hrdata = (s_dp_reg && !s_write_reg) ? mem[s_addr_reg[13:2]] : '0;

  // Monitor: one line per completed response, compared against the expected queue.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.cmd_valid && bus.cmd_ready) acc_cyc.push_back(cyc);
        if (bus.htrans == 2'b10 && bus.hready) ns_cyc.push_back(cyc);
        if (bus.rsp_valid && bus.rsp_ready) begin
          rsp_cyc.push_back(cyc);
          rsp_seen++;
          $display("rsp %0d: rdata=0x%08h error=%0b cycle=%0d", rsp_seen, bus.rsp_rdata, bus.rsp_error, cyc);
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", {63'd0, bus.rsp_valid}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e[31:0]);
            check("rsp_error", bus.rsp_error, e[32]);
          end
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int n = 0;
    logic acc = 1'b0;
    exp_q.push_back({exp_err, exp_rdata});
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_size  = 3'd2;
    bus.cmd_wdata = wdata;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accept", acc, 1);
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_seen < target && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rsp_count", rsp_seen, target);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    ns_cyc.delete();
    rsp_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int gaps;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_size  = 3'd2;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_htrans", bus.htrans, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_haddr", bus.haddr, 0);
    check("rst_hwdata", bus.hwdata, 0);
    check("rst_hburst", bus.hburst, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_cmd_ready", bus.cmd_ready, 1);

    // Write then read 0x1000, zero wait states
    clear_logs();
    base = rsp_seen;
    issue(1'b1, 32'h1000, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(1'b0, 32'h1000, 32'h0, 32'hDEAD_BEEF, 1'b0);
    wait_rsp(base + 2);
    check("t1_nonseq_latency", ns_cyc[0] - acc_cyc[0], 1);
    check("t1_rsp_latency", rsp_cyc[0] - acc_cyc[0], 3);
    check("t1_nonseq_latency_rd", ns_cyc[1] - acc_cyc[1], 1);

    // 8 back-to-back writes then 8 reads
    clear_logs();
    base = rsp_seen;
    for (int i = 0; i < 8; i++) issue(1'b1, 32'(4 * i), 32'hA5A5_0000 + 32'(i), 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) issue(1'b0, 32'(4 * i), 32'h0, 32'hA5A5_0000 + 32'(i), 1'b0);
    wait_rsp(base + 16);
    gaps = 0;
    for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 1) gaps++;
    check("b2b_accept_gaps", gaps, 0);
    gaps = 0;
    for (int i = 1; i < ns_cyc.size(); i++) if (ns_cyc[i] - ns_cyc[i-1] != 1) gaps++;
    check("b2b_nonseq_gaps", gaps, 0);
    check("b2b_nonseq_count", ns_cyc.size(), 16);

    // 3 wait states on a read, pipelined write held in address phase
    clear_logs();
    base = rsp_seen;
    wait_addr = 32'h4;
    issue(1'b0, 32'h4, 32'h0, 32'hA5A5_0001, 1'b0);
    issue(1'b1, 32'h40, 32'h1357_9BDF, 32'h0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("ws_hready", bus.hready, 0);
      check("ws_haddr", bus.haddr, 32'h40);
      check("ws_htrans", bus.htrans, 2'b10);
    end
    wait_rsp(base + 2);
    check("ws_rsp_latency", rsp_cyc[0] - acc_cyc[0], 6);

    // 3 wait states on a write: hwdata held stable
    clear_logs();
    base = rsp_seen;
    wait_addr = 32'h48;
    issue(1'b1, 32'h48, 32'h0BAD_F00D, 32'h0, 1'b0);
    issue(1'b0, 32'h40, 32'h0, 32'h1357_9BDF, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("wsw_hwdata", bus.hwdata, 32'h0BAD_F00D);
      check("wsw_haddr", bus.haddr, 32'h40);
      check("wsw_hwrite", bus.hwrite, 0);
    end
    wait_rsp(base + 2);
    wait_addr = 32'hFFFF_FFFF;

    // ERROR on a write with a read pending in the address phase
    clear_logs();
    base = rsp_seen;
    err_addr = 32'h2000;
    issue(1'b1, 32'h2000, 32'h1111_1111, 32'h0, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 32'hA5A5_0000, 1'b0);
    @(negedge clk);
    check("err1_hresp", bus.hresp, 1);
    check("err1_hready", bus.hready, 0);
    @(negedge clk);
    check("err2_htrans", bus.htrans, 2'b00);
    check("err2_hready", bus.hready, 1);
    check("err2_hresp", bus.hresp, 1);
    @(negedge clk);
    check("replay_htrans", bus.htrans, 2'b10);
    check("replay_haddr", bus.haddr, 32'h0);
    wait_rsp(base + 2);
    check("err_nonseq_count", ns_cyc.size(), 2);
    err_addr = 32'hFFFF_FFFF;

    // Response back-pressure: six reads, only four accepted while rsp_ready is low
    clear_logs();
    base = rsp_seen;
    bus.rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) issue(1'b0, 32'(8 + 4 * i), 32'h0, 32'hA5A5_0002 + 32'(i), 1'b0);
      end
    join_none
    repeat (15) @(negedge clk);
    check("bp_accepted", acc_cyc.size(), DEPTH);
    check("bp_cmd_ready", bus.cmd_ready, 0);
    check("bp_rsp_valid", bus.rsp_valid, 1);
    check("bp_head_rdata", bus.rsp_rdata, 32'hA5A5_0002);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_rsp(base + 6);
    check("bp_accepted_all", acc_cyc.size(), 6);

    // Reset mid data phase with two responses queued
    clear_logs();
    bus.rsp_ready = 1'b0;
    wait_addr = 32'hC;
    issue(1'b0, 32'h0, 32'h0, 32'hA5A5_0000, 1'b0);
    issue(1'b0, 32'h4, 32'h0, 32'hA5A5_0001, 1'b0);
    issue(1'b0, 32'hC, 32'h0, 32'hA5A5_0003, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_rsp_valid", bus.rsp_valid, 1);
    check("pre_rst_dataphase_wait", bus.hready, 0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_htrans", bus.htrans, 2'b00);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 0);
    check("mid_rst_rsp_rdata", bus.rsp_rdata, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_addr = 32'hFFFF_FFFF;
    bus.rsp_ready = 1'b1;
    clear_logs();
    base = rsp_seen;
    issue(1'b0, 32'h48, 32'h0, 32'h0BAD_F00D, 1'b0);
    wait_rsp(base + 1);
    check("post_rst_rsp_latency", rsp_cyc[0] - acc_cyc[0], 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
